mips_data_mem_responder: RTL and testbench

//   Memory-side responder for the CPU data port in its bus (waitrequest) form. Holds a

---
 rtl/mips_data_mem_responder.sv | 134 +++++++++++++
 tb/tb_mips_data_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_data_mem_responder.sv
// Word-organised data RAM behind a waitrequest-style bus port with a fixed stall per access.
// Build macro RANDOM_WAIT_EN adds an LFSR-driven 0..3 cycle extra stall per accepted request.
module mips_data_mem_responder #(
   parameter logic [31:0] ADDR_BASE   = 32'h0000_1000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2,
   parameter string       INIT_FILE   = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic        read,
   input  logic        write,
   input  logic [3:0]  byteenable,
   input  logic [31:0] writedata,
   output logic        waitrequest,
   output logic [31:0] readdata,
   output logic        err
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

   logic [1:0]  r_state;
   logic [4:0]  r_count;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [3:0]  r_be;
   logic        r_rd;
   logic        r_wr;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic             w_req;
   logic [31:0]      w_addr_sel;
   logic [31:0]      w_offset;
   logic [IDX_W-1:0] w_idx;
   logic             w_rd_sel;
   logic             w_wr_sel;
   logic             w_inrange;
   logic             w_bad;
   logic [31:0]      w_rdata_nxt;
   logic [4:0]       w_stall;
   logic             w_unused;

   assign w_req       = read | write;
   assign waitrequest = w_req && (r_state != S_ACK);

   // In IDLE the live request is decoded; afterwards the latched copy drives decode.
   assign w_addr_sel  = (r_state == S_IDLE) ? address : r_addr;
   assign w_rd_sel    = (r_state == S_IDLE) ? read    : r_rd;
   assign w_wr_sel    = (r_state == S_IDLE) ? write   : r_wr;
   assign w_offset    = w_addr_sel - ADDR_BASE;
   assign w_idx       = w_offset[IDX_W+1:2];
   assign w_inrange   = (w_addr_sel >= ADDR_BASE) &&
                        ({2'b00, w_offset[31:2]} < 32'(DEPTH_WORDS));
   assign w_bad       = !w_inrange || (w_rd_sel && w_wr_sel);
   assign w_rdata_nxt = (w_rd_sel && !w_wr_sel && w_inrange) ? r_mem[w_idx] : 32'h0;
   assign w_unused    = ^w_offset[1:0];

`ifdef RANDOM_WAIT_EN
   logic [7:0] r_lfsr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lfsr <= 8'hA5;
      end else if (r_state == S_IDLE && w_req) begin
         r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
      end
   end

   assign w_stall = 5'(WAIT_CYCLES) + {3'b000, r_lfsr[1:0]};
`else
   assign w_stall = 5'(WAIT_CYCLES);
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= S_IDLE;
         r_count  <= 5'd0;
         readdata <= 32'h0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_count <= w_stall;
                  if (w_stall != 5'd0) begin
                     r_state <= S_WAIT;
                  end else begin
                     r_state  <= S_ACK;
                     readdata <= w_rdata_nxt;
                     err      <= w_bad;
                  end
               end
            end
            S_WAIT: begin
               if (!w_req) begin
                  r_state <= S_IDLE;
                  r_count <= 5'd0;
               end else if (r_count == 5'd1) begin
                  r_state  <= S_ACK;
                  r_count  <= 5'd0;
                  readdata <= w_rdata_nxt;
                  err      <= w_bad;
               end else begin
                  r_count <= r_count - 5'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == S_IDLE && w_req) begin
         r_addr  <= address;
         r_wdata <= writedata;
         r_be    <= byteenable;
         r_rd    <= read;
         r_wr    <= write;
      end
   end

   // Writes land on the edge that ends ACK, so an abort or reset before then discards them.
   always_ff @(posedge clk) begin
      if (r_state == S_ACK && r_wr && !r_rd && w_inrange) begin
         for (int i = 0; i < 4; i++) begin
            if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
         end
      end
   end
endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Bench for mips_data_mem_responder: table-driven accesses plus abort, reset and back-to-back sequences.
module tb_mips_data_mem_responder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic [31:0] address, writedata, readdata;
   logic        read, write, waitrequest, err;
   logic [3:0]  byteenable;

   logic [31:0] address_z, writedata_z, readdata_z;
   logic        read_z, write_z, waitrequest_z, err_z;
   logic [3:0]  byteenable_z;

   mips_data_mem_responder #(.WAIT_CYCLES(2)) u_dut (
      .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
      .byteenable(byteenable), .writedata(writedata), .waitrequest(waitrequest),
      .readdata(readdata), .err(err));

   mips_data_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .reset(reset), .address(address_z), .read(read_z), .write(write_z),
      .byteenable(byteenable_z), .writedata(writedata_z), .waitrequest(waitrequest_z),
      .readdata(readdata_z), .err(err_z));

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      logic        chk_rd;
   } exp_t;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[22];
   int   n_cmp  = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic access(input string name, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
      exp_t e;
      int   n;
      bit   ok;
      e.rdata = exp_rd; e.err = exp_err; e.lat = 3; e.chk_rd = rd;
      sb.push_back(e);
      @(posedge clk); #1;
      read = rd; write = wr; address = a; byteenable = be; writedata = wd;
      n = 0; ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (!waitrequest) begin
            ok = 1'b1;
            break;
         end
         n++;
      end
      e = sb.pop_front();
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL %s ack timeout: waitrequest still high after 40 cycles, expected low after %0d", name, e.lat);
      end else begin
         check({name, " stall"}, 32'(n), 32'(e.lat));
         if (e.chk_rd) check({name, " readdata"}, readdata, e.rdata);
         check1({name, " err"}, err, e.err);
      end
      @(posedge clk); #1;
      read = 1'b0; write = 1'b0;
      @(negedge clk);
      check1({name, " err pulse end"}, err, 1'b0);
   endtask

   task automatic b2b(input string name, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd, input logic [31:0] exp_rd);
      exp_t e;
      e.rdata = exp_rd; e.err = 1'b0; e.lat = 1; e.chk_rd = rd;
      sb.push_back(e);
      read_z = rd; write_z = wr; address_z = a; byteenable_z = 4'hF; writedata_z = wd;
      @(negedge clk);
      check1({name, " waitrequest issue"}, waitrequest_z, 1'b1);
      @(posedge clk); #1;
      @(negedge clk);
      e = sb.pop_front();
      check1({name, " waitrequest ack"}, waitrequest_z, 1'b0);
      if (e.chk_rd) check({name, " readdata"}, readdata_z, e.rdata);
      check1({name, " err"}, err_z, e.err);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b0, 1'b1, 32'h0000_1000, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0};
      vecs[1]  = '{1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 32'h0000_1004, 4'hF, 32'h1122_3344, 32'h0, 1'b0};
      vecs[3]  = '{1'b0, 1'b1, 32'h0000_1004, 4'h5, 32'hAABB_CCDD, 32'h0, 1'b0};
      vecs[4]  = '{1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 32'h0000_0FFC, 4'hF, 32'h0,         32'h0, 1'b1};
      vecs[6]  = '{1'b1, 1'b0, 32'h0000_2000, 4'hF, 32'h0,         32'h0, 1'b1};
      vecs[7]  = '{1'b0, 1'b1, 32'h0000_0FFC, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 32'h0000_2000, 4'hF, 32'hFFFF_FFFF, 32'h0, 1'b1};
      vecs[9]  = '{1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[10] = '{1'b1, 1'b0, 32'h0000_1004, 4'hF, 32'h0,         32'h11BB_33DD, 1'b0};
      vecs[11] = '{1'b1, 1'b1, 32'h0000_1000, 4'hF, 32'h0,         32'h0, 1'b1};
      vecs[12] = '{1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0,         32'hDEAD_BEEF, 1'b0};
      vecs[13] = '{1'b0, 1'b1, 32'h0000_100B, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[15] = '{1'b0, 1'b1, 32'h0000_1FFC, 4'hF, 32'h5A5A_5A5A, 32'h0, 1'b0};
      vecs[16] = '{1'b1, 1'b0, 32'h0000_1FFE, 4'hF, 32'h0,         32'h5A5A_5A5A, 1'b0};
      vecs[17] = '{1'b0, 1'b1, 32'h0000_1008, 4'h0, 32'h0,         32'h0, 1'b0};
      vecs[18] = '{1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0,         32'hCAFE_F00D, 1'b0};
      vecs[19] = '{1'b0, 1'b1, 32'h0000_1008, 4'h8, 32'h7700_0000, 32'h0, 1'b0};
      vecs[20] = '{1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0,         32'h77FE_F00D, 1'b0};
      vecs[21] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 4'hF, 32'h0,         32'h0, 1'b1};

      reset = 1'b0;
      read = 1'b0; write = 1'b0; address = '0; byteenable = '0; writedata = '0;
      read_z = 1'b0; write_z = 1'b0; address_z = '0; byteenable_z = '0; writedata_z = '0;
      #12;
      check1("reset waitrequest", waitrequest, 1'b0);
      check("reset readdata", readdata, 32'h0);
      check1("reset err", err, 1'b0);
      check1("reset waitrequest dut0", waitrequest_z, 1'b0);
      check("reset readdata dut0", readdata_z, 32'h0);
      check1("reset err dut0", err_z, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;

      for (int i = 0; i < 22; i++) begin
         access($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].be,
                vecs[i].wdata, vecs[i].rdata, vecs[i].err);
      end

      // Request dropped during WAIT: abort without touching the word.
      @(posedge clk); #1;
      write = 1'b1; read = 1'b0; address = 32'h0000_1008; byteenable = 4'hF; writedata = 32'h0;
      @(negedge clk);
      check1("abort waitrequest issue", waitrequest, 1'b1);
      @(posedge clk); #1;
      write = 1'b0;
      @(negedge clk);
      check1("abort waitrequest dropped", waitrequest, 1'b0);
      check1("abort err", err, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check1("abort err after", err, 1'b0);
      access("abort readback", 1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0, 32'h77FE_F00D, 1'b0);

      // Reset in the last WAIT cycle of a write.
      @(posedge clk); #1;
      write = 1'b1; read = 1'b0; address = 32'h0000_1008; byteenable = 4'hF; writedata = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      check("rst readdata cleared", readdata, 32'h0);
      check1("rst waitrequest follows req", waitrequest, 1'b1);
      check1("rst err", err, 1'b0);
      @(negedge clk);
      check1("rst waitrequest held", waitrequest, 1'b1);
      write = 1'b0;
      #1;
      check1("rst waitrequest released", waitrequest, 1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      access("rst readback", 1'b1, 1'b0, 32'h0000_1008, 4'hF, 32'h0, 32'h77FE_F00D, 1'b0);

      // Zero-wait instance, back-to-back requests with no gap.
      @(posedge clk); #1;
      b2b("b2b w0", 1'b0, 1'b1, 32'h0000_1000, 32'h0102_0304, 32'h0);
      b2b("b2b w1", 1'b0, 1'b1, 32'h0000_1004, 32'h0A0B_0C0D, 32'h0);
      b2b("b2b r0", 1'b1, 1'b0, 32'h0000_1000, 32'h0,         32'h0102_0304);
      b2b("b2b r1", 1'b1, 1'b0, 32'h0000_1004, 32'h0,         32'h0A0B_0C0D);
      b2b("b2b r0 again", 1'b1, 1'b0, 32'h0000_1000, 32'h0,   32'h0102_0304);
      read_z = 1'b0; write_z = 1'b0;
      @(negedge clk);
      check1("b2b idle waitrequest", waitrequest_z, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
